// File: rtl/barrel_shift_sched_pkg.sv
// Shared types for the shifter scheduler: FSM states, result owner and shift direction encodings.
// Pure declarations; no latency or backpressure of its own.
package barrel_shift_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic OWN_ALIGN = 1'b0;
   localparam logic OWN_NORM  = 1'b1;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/barrel_shift_sched_if.sv
// Request, shifter and result signals of the scheduler; slave = scheduler side, master = requesters/shifter side.
// Wiring only; handshakes are req/ack on the request side and valid/ready on the result side.
interface barrel_shift_sched_if #(
   parameter int SWR = 26,
   parameter int EW  = 8
) ();
   logic           al_req_i;
   logic [EW-1:0]  al_shift_i;
   logic [SWR-1:0] al_data_i;
   logic           al_ack_o;

   logic           nm_req_i;
   logic [EW-1:0]  nm_shift_i;
   logic [SWR-1:0] nm_data_i;
   logic           nm_bit_i;
   logic           nm_ack_o;

   logic           sh_load_o;
   logic [EW-1:0]  sh_value_o;
   logic [SWR-1:0] sh_data_o;
   logic           sh_left_right_o;
   logic           sh_bit_o;
   logic [SWR-1:0] sh_result_i;

   logic           res_valid_o;
   logic           res_owner_o;
   logic [SWR-1:0] res_data_o;
   logic           res_sat_o;
   logic           res_ready_i;

   modport slave (
      input  al_req_i, al_shift_i, al_data_i, nm_req_i, nm_shift_i, nm_data_i, nm_bit_i,
      input  sh_result_i, res_ready_i,
      output al_ack_o, nm_ack_o, sh_load_o, sh_value_o, sh_data_o, sh_left_right_o, sh_bit_o,
      output res_valid_o, res_owner_o, res_data_o, res_sat_o
   );

   modport master (
      output al_req_i, al_shift_i, al_data_i, nm_req_i, nm_shift_i, nm_data_i, nm_bit_i,
      output sh_result_i, res_ready_i,
      input  al_ack_o, nm_ack_o, sh_load_o, sh_value_o, sh_data_o, sh_left_right_o, sh_bit_o,
      input  res_valid_o, res_owner_o, res_data_o, res_sat_o
   );
endinterface

// File: rtl/shift_sched_arb.sv
// Two-way align/norm arbiter; combinational winner, pointer updates on grant. SHIFT_SCHED_RR_EN selects
// round-robin, otherwise fixed norm-over-align priority. No backpressure: the FSM decides when to grant.
module shift_sched_arb
   import barrel_shift_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic al_req,
   input  logic nm_req,
   input  logic grant,
   output logic winner
);

`ifdef SHIFT_SCHED_RR_EN
   logic ptr_q;

   always_comb begin
      winner = OWN_ALIGN;
      if (al_req && nm_req) winner = ptr_q;
      else if (nm_req)      winner = OWN_NORM;
   end

   // pointer moves to the side that just lost so it wins the next tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        ptr_q <= OWN_ALIGN;
      else if (grant) ptr_q <= ~winner;
   end
`else
   logic unused_arb;
   assign unused_arb = ^{clk, rst, grant, al_req};
   assign winner     = nm_req ? OWN_NORM : OWN_ALIGN;
`endif

endmodule

// File: rtl/barrel_shift_sched.sv
// Time-shares one barrel shifter between align (right) and norm (left) requests; arbitration via SHIFT_SCHED_RR_EN.
// Latency 3 cycles req-to-result, one transaction per 4 cycles; result held in DONE until res_ready_i.
module barrel_shift_sched
   import barrel_shift_sched_pkg::*;
#(
   parameter int SWR = 26,
   parameter int EW  = 8
) (
   input  logic                clk,
   input  logic                rst,
   barrel_shift_sched_if.slave bus
);
   localparam logic [EW-1:0] SWR_V = EW'(SWR);

   state_t         state_q, state_d;
   logic           owner_q, sat_q, lr_q, fill_q;
   logic [EW-1:0]  value_q;
   logic [SWR-1:0] data_q, res_q;
   logic           any_req, grant, winner, sel_sat;
   logic [EW-1:0]  sel_shift;
   logic [SWR-1:0] sel_data;

   assign any_req = bus.al_req_i | bus.nm_req_i;
   assign grant   = (state_q == ST_IDLE) && any_req;

   shift_sched_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .al_req (bus.al_req_i),
      .nm_req (bus.nm_req_i),
      .grant  (grant),
      .winner (winner)
   );

   always_comb begin
      sel_shift = (winner == OWN_NORM) ? bus.nm_shift_i : bus.al_shift_i;
      sel_data  = (winner == OWN_NORM) ? bus.nm_data_i  : bus.al_data_i;
      sel_sat   = (sel_shift >= SWR_V);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      bus.sh_load_o   = 1'b0;
      bus.al_ack_o    = 1'b0;
      bus.nm_ack_o    = 1'b0;
      bus.res_valid_o = 1'b0;
      case (state_q)
         ST_IDLE: if (any_req) state_d = ST_LOAD;
         ST_LOAD: begin
            state_d       = ST_CAPT;
            bus.sh_load_o = 1'b1;
            bus.al_ack_o  = (owner_q == OWN_ALIGN);
            bus.nm_ack_o  = (owner_q == OWN_NORM);
         end
         ST_CAPT: state_d = ST_DONE;
         ST_DONE: begin
            bus.res_valid_o = 1'b1;
            if (bus.res_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // shifter operands are latched on the grant edge, so they change only when entering LOAD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_ALIGN;
         sat_q   <= 1'b0;
         lr_q    <= DIR_RIGHT;
         fill_q  <= 1'b0;
         value_q <= '0;
         data_q  <= '0;
         res_q   <= '0;
      end else begin
         if (grant) begin
            owner_q <= winner;
            sat_q   <= sel_sat;
            value_q <= sel_sat ? SWR_V : sel_shift;
            data_q  <= sel_data;
            lr_q    <= (winner == OWN_NORM) ? DIR_LEFT : DIR_RIGHT;
            fill_q  <= (winner == OWN_NORM) && bus.nm_bit_i;
         end
         if (state_q == ST_CAPT) res_q <= bus.sh_result_i;
      end
   end

   assign bus.sh_value_o      = value_q;
   assign bus.sh_data_o       = data_q;
   assign bus.sh_left_right_o = lr_q;
   assign bus.sh_bit_o        = fill_q;
   assign bus.res_owner_o     = owner_q;
   assign bus.res_sat_o       = sat_q;
   assign bus.res_data_o      = res_q;

endmodule
